spi_mmio: RTL
=============

// Module: spi_mmio
// PURPOSE
//  Memory-mapped SPI master (mode 0, MSB first) on the processor's data-request channel, beside the RAM.
//  Owns TX/RX byte FIFOs and the shift engine, replacing the instant-response SPI logic at top level.
//  The top-level mux takes rs_en/rs_data from here exactly as it takes them from the RAM.
// PARAMETERS
//  BASE          32'h10024000  base of the 4 KiB register window
//  FIFO_LGDEPTH  2             log2 depth of each FIFO (depth 4)
//  DIV_RESET     12'd0         reset value of SCKDIV
// PORTS
//  clk         in   1   clock
//  reset       in   1   synchronous reset, active-high
//  rq_en       in   1   request valid; block is always ready
//  rq_addr     in   32  byte address
//  rq_iswrite  in   1   1 = write, 0 = read
//  rq_data     in   32  write data
//  rq_hit      out  1   combinational: rq_addr[31:12] == BASE[31:12]
//  rs_en       out  1   response valid; consumer is always ready
//  rs_data     out  32  response data
//  spi_clk     out  1   SCK, idle low
//  spi_cs      out  1   chip select, active-low
//  spi_mosi    out  1   master out
//  spi_miso    in   1   master in
// BEHAVIOUR
//  Reset: rs_en=0, rs_data=0, spi_clk=0, spi_cs=1, spi_mosi=0, both FIFOs empty, state IDLE, SCKDIV=DIV_RESET.
//  Decode is on offset rq_addr[11:0]; all state effects require rq_en && rq_hit.
//  Registers:
//  - 0x000 SCKDIV: R/W, bits [11:0].
//  - 0x048 TXDATA: write enqueues rq_data[7:0] unless TX is full; a write while full is silently dropped.
//    Read returns {tx_full, 31'b0}.
//  - 0x04C RXDATA: read returns {rx_empty, 23'b0, byte}; a read while non-empty pops. A read while empty returns byte=0.
//    Write is ignored.
//  - Other offsets: reads return 0, writes are ignored.
//  Response: rs_en is asserted exactly 1 cycle after each hit, for reads and writes alike. rs_data=0 for writes.
//  Full/empty flags and read data are taken from state at the start of the request cycle.
//  Shift FSM, with half period H = SCKDIV+1 clk cycles:
//  - IDLE: TX non-empty -> pop byte into shreg, spi_cs=0, mosi=shreg[7], go LOW.
//  - LOW: after H cycles, spi_clk=1, sample miso into rxsh[0] (shift left), go HIGH.
//  - HIGH: after H cycles, spi_clk=0, bitcnt+1.
//    - If bitcnt was 7: push rxsh to RX. If TX non-empty, load next byte and go LOW with cs held low; else spi_cs=1, go IDLE.
//    - Otherwise shift shreg left and go LOW.
//  Byte time is 16*H cycles; back-to-back bytes have no idle gap.
//  Boundaries:
//  - RX full at byte completion: new byte is dropped, FIFO is unchanged.
//  - Same-cycle pop + push on RX: both take effect, count unchanged. This holds for full RX; a same-cycle RX read
//    while empty returns empty and the push still lands.
//  - Same-cycle TX enqueue + FSM pop: both take effect; the enqueue is judged against the start-of-cycle full flag.
//  - SCKDIV written mid-byte: takes effect at the next half-period boundary.
//  - Reset mid-byte: transfer is abandoned, cs=1 in the next cycle, FIFO contents are discarded.
//  - Counter widths: bitcnt 3b, half-period counter 12b, FIFO pointers FIFO_LGDEPTH+1 bits (wrap bit for full/empty).
// CONFIGURATION
//  SPI_LOOPBACK_EN:
//  - Defined: the miso sample uses spi_mosi internally and spi_miso is ignored; the RX byte equals the TX byte.
//  - Undefined: the miso sample uses the spi_miso pin.
// STRUCTURE
//  Package spi_mmio_pkg holds the offset localparams (SCKDIV, TXDATA, RXDATA) and the FSM state enum {IDLE, LOW, HIGH}.
//  Sub-module spi_fifo: sync FIFO (8-bit, 2**FIFO_LGDEPTH deep, push/pop/full/empty), instanced for TX and RX.
// TESTING
//  1 Reset: spi_cs=1, spi_clk=0, rs_en=0. Read 0x1002404C -> rs_en at +1 cycle, rs_data=32'h80000000.
//  2 Loopback: SCKDIV=0, write TXDATA 8'hA5. Exactly 8 rising SCK edges, 16 clk from IDLE exit; cs low throughout.
//    Read RXDATA -> 32'h000000A5, next read -> 32'h80000000.
//  3 Write 6 bytes 01..06 back-to-back with SCKDIV=3. TXDATA read shows bit31=1 once full.
//    Bytes 01..05 appear on mosi (first popped at once, 4 queued), 06 is dropped; cs stays low across bytes, no gaps.
//  4 RX overflow: loopback, send 5 bytes without reading. RX holds the first 4; the 5th is dropped.
//    The 4 reads return 11,22,33,44, then empty.
//  5 Same-cycle pop/push: RX full, issue the RXDATA read in the cycle the 5th byte completes.
//    The read returns byte 1; the FIFO then holds bytes 2..5.
//  6 Reset asserted at bit 3 of a transfer: next cycle cs=1, spi_clk=0, TX/RX empty, SCKDIV reads DIV_RESET.
//    An off-window address (0x10030000) gives rq_hit=0 and no rs_en.

Source files
------------

// File: rtl/spi_mmio_pkg.sv
// Shared register offsets and shift-engine state encoding for the spi_mmio block.
package spi_mmio_pkg;

    localparam logic [11:0] SCKDIV = 12'h000;
    localparam logic [11:0] TXDATA = 12'h048;
    localparam logic [11:0] RXDATA = 12'h04C;

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

endpackage

// File: rtl/spi_mmio_fifo.sv
// Synchronous 8-bit byte FIFO with wrap-bit pointers; a push into a full FIFO lands only alongside a pop.
module spi_fifo #(
    parameter int LGDEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    logic [7:0]       mem [2**LGDEPTH];
    logic [LGDEPTH:0] wr_ptr;
    logic [LGDEPTH:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = wr_ptr == rd_ptr;
    assign full     = (wr_ptr[LGDEPTH] != rd_ptr[LGDEPTH]) &&
                      (wr_ptr[LGDEPTH-1:0] == rd_ptr[LGDEPTH-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[LGDEPTH-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[LGDEPTH-1:0]] <= push_data;
    end

endmodule

// File: rtl/spi_mmio.sv
// Memory-mapped SPI master (mode 0, MSB first) with TX/RX byte FIFOs.
// Define SPI_LOOPBACK_EN to sample the master's own mosi instead of the spi_miso pin.
module spi_mmio
    import spi_mmio_pkg::*;
#(
    parameter logic [31:0] BASE         = 32'h10024000,
    parameter int          FIFO_LGDEPTH = 2,
    parameter logic [11:0] DIV_RESET    = 12'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rq_en,
    input  logic [31:0] rq_addr,
    input  logic        rq_iswrite,
    input  logic [31:0] rq_data,
    output logic        rq_hit,
    output logic        rs_en,
    output logic [31:0] rs_data,
    output logic        spi_clk,
    output logic        spi_cs,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    state_t      state, state_next;
    logic [11:0] offset, sckdiv, hcnt, hlim;
    logic [2:0]  bitcnt;
    logic [7:0]  shreg, rxsh, tx_data, rx_data;
    logic        rd_req, wr_req, half_done, last_bit, miso_bit;
    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic        rx_push, rx_pop, rx_full, rx_empty;
    logic [31:0] rd_val;
    logic        unused;

    assign rq_hit    = rq_addr[31:12] == BASE[31:12];
    assign offset    = rq_addr[11:0];
    assign wr_req    = rq_en && rq_hit && rq_iswrite;
    assign rd_req    = rq_en && rq_hit && !rq_iswrite;
    assign tx_push   = wr_req && offset == TXDATA && !tx_full;
    assign rx_pop    = rd_req && offset == RXDATA;
    assign half_done = hcnt == hlim;
    assign last_bit  = bitcnt == 3'd7;
    assign unused    = ^{rq_data[31:12], spi_miso, rx_full};

`ifdef SPI_LOOPBACK_EN
    assign miso_bit = spi_mosi;
`else
    assign miso_bit = spi_miso;
`endif

    spi_fifo #(.LGDEPTH(FIFO_LGDEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_push), .push_data(rq_data[7:0]),
        .pop(tx_pop), .pop_data(tx_data), .full(tx_full), .empty(tx_empty)
    );

    spi_fifo #(.LGDEPTH(FIFO_LGDEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .push_data(rxsh),
        .pop(rx_pop), .pop_data(rx_data), .full(rx_full), .empty(rx_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!tx_empty) state_next = LOW;
            LOW:     if (half_done) state_next = HIGH;
            HIGH:    if (half_done) state_next = (last_bit && tx_empty) ? IDLE : LOW;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_pop  = 1'b0;
        rx_push = 1'b0;
        case (state)
            IDLE: tx_pop = !tx_empty;
            HIGH: if (half_done && last_bit) begin
                rx_push = 1'b1;
                tx_pop  = !tx_empty;
            end
            default: ;
        endcase
    end

    // The half-period limit is latched at each boundary so an SCKDIV write only affects the next half.
    always_ff @(posedge clk) begin
        if (reset) begin
            sckdiv   <= DIV_RESET;
            hcnt     <= '0;
            hlim     <= '0;
            bitcnt   <= '0;
            shreg    <= '0;
            rxsh     <= '0;
            spi_clk  <= 1'b0;
            spi_cs   <= 1'b1;
            spi_mosi <= 1'b0;
        end else begin
            if (wr_req && offset == SCKDIV) sckdiv <= rq_data[11:0];
            case (state)
                IDLE: if (tx_pop) begin
                    shreg    <= tx_data;
                    spi_mosi <= tx_data[7];
                    spi_cs   <= 1'b0;
                    hcnt     <= '0;
                    hlim     <= sckdiv;
                    bitcnt   <= '0;
                end
                LOW: if (half_done) begin
                    spi_clk <= 1'b1;
                    rxsh    <= {rxsh[6:0], miso_bit};
                    hcnt    <= '0;
                    hlim    <= sckdiv;
                end else begin
                    hcnt <= hcnt + 12'd1;
                end
                HIGH: if (half_done) begin
                    spi_clk <= 1'b0;
                    bitcnt  <= bitcnt + 3'd1;
                    hcnt    <= '0;
                    hlim    <= sckdiv;
                    if (last_bit) begin
                        if (tx_pop) begin
                            shreg    <= tx_data;
                            spi_mosi <= tx_data[7];
                        end else begin
                            spi_cs <= 1'b1;
                        end
                    end else begin
                        shreg    <= {shreg[6:0], 1'b0};
                        spi_mosi <= shreg[6];
                    end
                end else begin
                    hcnt <= hcnt + 12'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_val = '0;
        case (offset)
            SCKDIV:  rd_val = {20'b0, sckdiv};
            TXDATA:  rd_val = {tx_full, 31'b0};
            RXDATA:  rd_val = {rx_empty, 23'b0, rx_empty ? 8'h00 : rx_data};
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rs_en   <= 1'b0;
            rs_data <= '0;
        end else begin
            rs_en   <= rq_en && rq_hit;
            rs_data <= rd_req ? rd_val : '0;
        end
    end

endmodule
